rr_arbiter16: RTL and testbench
===============================

Name: rr_arbiter16

Overview:
Round-robin arbiter that shares one 16:1 single-bit select path between 16 requesters. Its registered 4-bit grant index drives the select input of the 16:1 single-bit mux, so exactly one requester's bit reaches the consumer at a time. A grant is held until the owner signals done, drops its request, or exceeds a programmable hold limit. Used wherever several units contend for one single-bit status or handshake line in the CPU.

Parameters:
MAX_HOLD, 16, maximum cycles a grant may be held; 0 disables the limit.
HOLD_W, 8, hold counter width; MAX_HOLD must be < 2**HOLD_W.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  16  request vector; bit i = requester i
done  input  1  one-cycle pulse from the current owner releasing the grant
gnt_valid  output  1  a grant is active
gnt_sel  output  4  index of the granted requester; drives the mux select
gnt_onehot  output  16  one-hot grant; all zero when gnt_valid=0
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- State machine: IDLE, GRANT, RELEASE. All outputs are registered.
- Reset values: state=IDLE, gnt_valid=0, gnt_sel=0, gnt_onehot=0, timeout=0, rotation pointer ptr=0, hold counter=0.
- IDLE:
  - If req!=0, pick the first set bit at index ptr, ptr+1, ..., 15, 0, ..., ptr-1 (mod 16).
  - Next cycle: gnt_sel=pick, gnt_onehot=1<<pick, gnt_valid=1, counter=0, state=GRANT.
  - Latency from req sampled to gnt_valid high is 1 cycle.
  - If req==0, stay in IDLE; outputs are unchanged at gnt_valid=0.
- GRANT: the counter increments every cycle, saturating at 2**HOLD_W-1. Release conditions, in priority order:
  1. done=1, or req[gnt_sel]=0: normal release.
  2. MAX_HOLD!=0 and counter==MAX_HOLD-1: forced release; timeout=1 for exactly the following cycle.
- On release:
  - Next cycle: gnt_valid=0, gnt_onehot=0, state=RELEASE.
  - gnt_sel keeps its value, so the mux stays stable.
  - ptr updates to (gnt_sel+1) mod 16, wrapping 15 -> 0.
- RELEASE: exactly one bubble cycle, then state=IDLE. Minimum gap between two grants is therefore 2 cycles of gnt_valid low... precisely, gnt_valid is low for the RELEASE cycle and the IDLE arbitration cycle, then rises.
- done while not in GRANT is ignored. Requests from non-owners during GRANT are ignored; there is no preemption.
- Simultaneous done and timeout: counted as a normal release; timeout stays 0.
- A requester holding req continuously is re-granted only after every other active requester has been served once (fairness bound of 16 grants).
- Reset mid-grant: everything returns to reset values on the next edge. ptr returns to 0, so requester 0 has top priority after reset.
- Invariant: gnt_onehot == (gnt_valid ? 1<<gnt_sel : 0) on every cycle.
- Invariant: gnt_valid=1 implies state==GRANT.

Decomposition:
- Shared package arb_pkg:
  - N_REQ=16 and SEL_W=4 constants.
  - arb_state_t enum {IDLE, GRANT, RELEASE}.
- One combinational sub-module, rr_pick16:
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: any (1 bit), idx[3:0].
  - Implementation: rotate req right by ptr, priority-encode the lowest set bit, add ptr mod 16.
  - It is reusable by other arbiters in the design.

Test Plan:
- Reset, then req=16'h0000 for 10 cycles -> gnt_valid=0, gnt_onehot=0, timeout=0 throughout.
- After reset, req=16'h0011 -> gnt_sel=0 one cycle later. done pulse -> 2 cycles of gnt_valid=0, then gnt_sel=4. Next done -> gnt_sel=0 again.
- Wrap-around: ptr=15 (grant 14 released), req=16'h8002 -> gnt_sel=15. After release -> gnt_sel=1.
- MAX_HOLD=4, req[3] held high, no done -> gnt_valid high exactly 4 cycles, then timeout=1 for 1 cycle. Re-grant of 3 follows when it is the only requester.
- done and counter==MAX_HOLD-1 in the same cycle -> release with timeout=0. Also check req[gnt_sel] dropping mid-grant -> release the next cycle.
- Assert reset while gnt_valid=1 and gnt_sel=9 -> all outputs reach reset values next cycle. With req=16'h0201 the next grant goes to 0.

Source files
------------

// File: rtl/rr_arbiter16_pkg.sv
// arb_pkg: shared constants and state type for the 16-way round-robin arbiters
package arb_pkg;
    localparam int N_REQ = 16;
    localparam int SEL_W = 4;
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
endpackage

// File: rtl/rr_arbiter16_if.sv
// rr_arbiter16_if: request/done inputs and grant outputs of the shared select path
interface rr_arbiter16_if;
    import arb_pkg::*;
    logic [N_REQ-1:0] req;
    logic             done;
    logic             gnt_valid;
    logic [SEL_W-1:0] gnt_sel;
    logic [N_REQ-1:0] gnt_onehot;
    logic             timeout;
    modport master (output req, done, input gnt_valid, gnt_sel, gnt_onehot, timeout);
    modport slave  (input req, done, output gnt_valid, gnt_sel, gnt_onehot, timeout);
endinterface

// File: rtl/rr_arbiter16_pick16.sv
// rr_pick16: first set request at or after ptr, searching upward with wrap
module rr_pick16
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx
);
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] off;
    assign rot = N_REQ'({req, req} >> ptr);
    assign any = |req;
    assign idx = off + ptr;
    // lowest set bit of the rotated vector is the distance from ptr to the winner
    always_comb begin
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) if (rot[i]) off = SEL_W'(i);
    end
endmodule

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: round-robin owner of a 16:1 single-bit select with hold limit
module rr_arbiter16
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input logic clk,
    input logic reset,
    rr_arbiter16_if.slave bus
);
    arb_state_t       state;
    logic [SEL_W-1:0] ptr;
    logic [HOLD_W-1:0] cnt;
    logic             any;
    logic [SEL_W-1:0] pick;
    logic             rel_norm;
    logic             rel_force;

    rr_pick16 u_pick (.req(bus.req), .ptr(ptr), .any(any), .idx(pick));

    assign rel_norm  = bus.done || !bus.req[bus.gnt_sel];
    assign rel_force = (MAX_HOLD != 0) && (cnt == HOLD_W'(MAX_HOLD - 1));

    // grant FSM; gnt_sel is left untouched on release so the mux select never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ptr            <= '0;
            cnt            <= '0;
            bus.gnt_valid  <= 1'b0;
            bus.gnt_sel    <= '0;
            bus.gnt_onehot <= '0;
            bus.timeout    <= 1'b0;
        end else begin
            bus.timeout <= 1'b0;
            case (state)
                IDLE: if (any) begin
                    state          <= GRANT;
                    cnt            <= '0;
                    bus.gnt_valid  <= 1'b1;
                    bus.gnt_sel    <= pick;
                    bus.gnt_onehot <= N_REQ'(1) << pick;
                end
                GRANT: if (rel_norm || rel_force) begin
                    state          <= RELEASE;
                    ptr            <= bus.gnt_sel + SEL_W'(1);
                    bus.gnt_valid  <= 1'b0;
                    bus.gnt_onehot <= '0;
                    bus.timeout    <= !rel_norm;
                end else begin
                    cnt <= (cnt == '1) ? cnt : cnt + HOLD_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: directed and randomized checks of rr_arbiter16 with MAX_HOLD=4
module tb_rr_arbiter16;
    localparam int MAXH = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    int m_ph = 0, m_s = 0, m_p = 0, m_h = 0;
    bit m_v = 0, m_t = 0;

    rr_arbiter16_if bus();
    rr_arbiter16 #(.MAX_HOLD(MAXH), .HOLD_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [21:0] obs();
        return {bus.gnt_valid, bus.gnt_sel, bus.gnt_onehot, bus.timeout};
    endfunction

    function automatic logic [21:0] model_out();
        logic [15:0] oh = m_v ? (16'h1 << m_s) : 16'h0;
        return {m_v, 4'(m_s), oh, m_t};
    endfunction

    // advance one clock; the model follows the textual rules: scan from the pointer,
    // release on done/dropped request, force release after MAXH cycles of ownership
    task automatic tick();
        int ph = m_ph, s = m_s, p = m_p, h = m_h;
        bit v = m_v, t = 0;
        if (reset) begin
            ph = 0; v = 0; s = 0; p = 0; h = 0;
        end else if (m_ph == 0) begin
            for (int k = 15; k >= 0; k--)
                if (bus.req[(m_p + k) % 16]) begin s = (m_p + k) % 16; v = 1; ph = 1; h = 1; end
        end else if (m_ph == 1) begin
            if (bus.done || !bus.req[m_s]) begin v = 0; ph = 2; p = (m_s + 1) % 16; end
            else if (MAXH != 0 && m_h == MAXH) begin v = 0; ph = 2; p = (m_s + 1) % 16; t = 1; end
            else h = m_h + 1;
        end else ph = 0;
        @(posedge clk);
        #1;
        m_ph = ph; m_v = v; m_s = s; m_p = p; m_h = h; m_t = t;
    endtask

    task automatic test_reset();
        bus.req = '0; bus.done = 1'b0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++;
        if (obs() !== 22'h0) begin fails++; $display("FAIL reset_state got %h want 0", obs()); end
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({bus.gnt_valid, bus.gnt_onehot, bus.timeout} !== 18'h0) begin
                fails++; $display("FAIL idle_quiet cycle %0d got %h want 0", i, obs());
            end
        end
    endtask

    task automatic test_rotation();
        bus.req = 16'h0011;
        tick();
        tests++;
        if (obs() !== {1'b1, 4'd0, 16'h0001, 1'b0}) begin fails++; $display("FAIL rot_first got %h", obs()); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tests++;
        if ({bus.gnt_valid, bus.gnt_sel} !== {1'b0, 4'd0}) begin fails++; $display("FAIL rot_release got %h want sel kept 0", obs()); end
        tick();
        tests++;
        if (bus.gnt_valid !== 1'b0) begin fails++; $display("FAIL rot_gap got %b want 0", bus.gnt_valid); end
        tick();
        tests++;
        if (obs() !== {1'b1, 4'd4, 16'h0010, 1'b0}) begin fails++; $display("FAIL rot_second got %h want sel 4", obs()); end
        bus.done = 1'b1; tick(); bus.done = 1'b0; tick(); tick();
        tests++;
        if (obs() !== {1'b1, 4'd0, 16'h0001, 1'b0}) begin fails++; $display("FAIL rot_third got %h want sel 0", obs()); end
        bus.req = '0; tick(); tick();
    endtask

    task automatic test_wrap();
        bus.req = 16'h4000; tick();
        tests++;
        if (bus.gnt_sel !== 4'd14) begin fails++; $display("FAIL wrap_14 got %0d want 14", bus.gnt_sel); end
        bus.req = '0; tick();
        bus.req = 16'h8002; tick(); tick();
        tests++;
        if (obs() !== {1'b1, 4'd15, 16'h8000, 1'b0}) begin fails++; $display("FAIL wrap_15 got %h want sel 15", obs()); end
        bus.done = 1'b1; tick(); bus.done = 1'b0; tick(); tick();
        tests++;
        if (obs() !== {1'b1, 4'd1, 16'h0002, 1'b0}) begin fails++; $display("FAIL wrap_1 got %h want sel 1", obs()); end
        bus.req = '0; tick(); tick();
    endtask

    task automatic test_timeout();
        bus.req = 16'h0008;
        for (int i = 0; i < MAXH; i++) begin
            tick();
            tests++;
            if (obs() !== {1'b1, 4'd3, 16'h0008, 1'b0}) begin fails++; $display("FAIL hold_cycle %0d got %h", i, obs()); end
        end
        tick();
        tests++;
        if (obs() !== {1'b0, 4'd3, 16'h0000, 1'b1}) begin fails++; $display("FAIL timeout_pulse got %h want timeout 1", obs()); end
        tick();
        tests++;
        if (obs() !== {1'b0, 4'd3, 16'h0000, 1'b0}) begin fails++; $display("FAIL timeout_clear got %h", obs()); end
        tick();
        tests++;
        if (obs() !== {1'b1, 4'd3, 16'h0008, 1'b0}) begin fails++; $display("FAIL timeout_regrant got %h want sel 3", obs()); end
    endtask

    task automatic test_done_at_limit();
        tick(); tick(); tick();
        tests++;
        if (bus.gnt_valid !== 1'b1) begin fails++; $display("FAIL limit_still_held got %b want 1", bus.gnt_valid); end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tests++;
        if (obs() !== {1'b0, 4'd3, 16'h0000, 1'b0}) begin fails++; $display("FAIL done_at_limit got %h want timeout 0", obs()); end
        tick(); tick();
        tests++;
        if (bus.gnt_valid !== 1'b1) begin fails++; $display("FAIL drop_grant got %b want 1", bus.gnt_valid); end
        tick();
        bus.req = '0; tick();
        tests++;
        if (obs() !== {1'b0, 4'd3, 16'h0000, 1'b0}) begin fails++; $display("FAIL req_drop got %h want released", obs()); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req = 16'h0200; tick();
        tests++;
        if (obs() !== {1'b1, 4'd9, 16'h0200, 1'b0}) begin fails++; $display("FAIL mid_grant9 got %h want sel 9", obs()); end
        bus.req = 16'h0201; reset = 1'b1; tick(); reset = 1'b0;
        tests++;
        if (obs() !== 22'h0) begin fails++; $display("FAIL mid_reset got %h want 0", obs()); end
        tick();
        tests++;
        if (obs() !== {1'b1, 4'd0, 16'h0001, 1'b0}) begin fails++; $display("FAIL post_reset got %h want sel 0", obs()); end
        bus.req = '0; tick(); tick();
    endtask

    task automatic test_random();
        logic [21:0] e;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0) bus.req = 16'($urandom) & 16'($urandom);
            bus.done = ($urandom_range(5) == 0);
            reset = ($urandom_range(199) == 0);
            tick();
            e = model_out();
            tests++;
            if (obs() !== e) begin fails++; $display("FAIL random cycle %0d got %h want %h", i, obs(), e); end
        end
        reset = 1'b0; bus.done = 1'b0;
    endtask

    initial begin
        bus.req = '0;
        bus.done = 1'b0;
        test_reset();
        test_rotation();
        test_wrap();
        test_timeout();
        test_done_at_limit();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
